// File: rtl/pagerank_scatter_stream.sv
`default_nettype none
// ============================================================================
// pagerank_scatter_stream : streams edges and emits rank[src]*inv_deg[src] beats
// Rev 1.0
// ============================================================================
module pagerank_scatter_stream #(
    parameter int NODES_IN_GRAPH = 32,
    parameter int EDGES_IN_GRAPH = 128,
    parameter int EDGE_ADDR_W    = $clog2(EDGES_IN_GRAPH)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            pagerank_enable,
    input  logic                            nextIteration,
    input  logic [31:0]                     edge_count,
    output logic                            edge_rd_en,
    output logic [EDGE_ADDR_W-1:0]          edge_rd_addr,
    input  logic [63:0]                     edge_rd_data,
    input  logic [NODES_IN_GRAPH-1:0][63:0] pagerank_current,
    input  logic [NODES_IN_GRAPH-1:0][31:0] inv_out_degree,
    output logic [63:0]                     page_rank_scatter,
    output logic [31:0]                     dest_id,
    output logic                            pagerank_ready,
    output logic                            scatter_operation_complete,
    output logic                            edge_error
);

    localparam int CNT_W  = EDGE_ADDR_W + 1;
    localparam int NODE_W = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
    localparam logic [CNT_W-1:0] MAX_EDGES = CNT_W'(EDGES_IN_GRAPH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] edge_total;
    logic [CNT_W-1:0] issue_idx;
    logic             rd_pending;
    logic [1:0][63:0] fifo_mem;
    logic             fifo_wr_ptr;
    logic             fifo_rd_ptr;
    logic [1:0]       fifo_occ;
    logic             out_valid;

    logic             count_clamp;
    logic [CNT_W-1:0] count_eff;
    logic             fifo_empty;
    logic             pop;
    logic [2:0]       inflight;
    logic [63:0]      head;
    logic [31:0]      head_src;
    logic [31:0]      head_dst;
    logic             head_in_range;
    logic [NODE_W-1:0] src_idx;
    logic [63:0]      contribution;
    logic             drain_done;

    assign count_clamp = edge_count > 32'(EDGES_IN_GRAPH);
    assign count_eff   = count_clamp ? MAX_EDGES : edge_count[CNT_W-1:0];

    assign fifo_empty = (fifo_occ == 2'd0);
    assign pop        = pagerank_enable && !fifo_empty;
    // Words in flight after this cycle's pop; bounded so the 2-entry skid never overflows.
    assign inflight   = 3'(fifo_occ) + 3'(rd_pending) - 3'(pop);

    assign edge_rd_en   = (state == S_ISSUE) && pagerank_enable && !nextIteration
                          && (inflight < 3'd2);
    assign edge_rd_addr = issue_idx[EDGE_ADDR_W-1:0];

    assign head          = fifo_mem[fifo_rd_ptr];
    assign head_src      = head[63:32];
    assign head_dst      = head[31:0];
    assign head_in_range = (head_src < 32'(NODES_IN_GRAPH)) && (head_dst < 32'(NODES_IN_GRAPH));
    assign src_idx       = head_src[NODE_W-1:0];
    // Q1.31 scaling: drop the 31 fractional bits of the 96-bit product, truncating.
    assign contribution  = 64'(({32'd0, pagerank_current[src_idx]} *
                                {64'd0, inv_out_degree[src_idx]}) >> 31);

    // The output register counts as empty if its beat is being presented this cycle.
    assign drain_done = !rd_pending && fifo_empty && !(out_valid && !pagerank_enable);

    assign pagerank_ready = out_valid && pagerank_enable;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                      <= S_IDLE;
            edge_total                 <= '0;
            issue_idx                  <= '0;
            rd_pending                 <= 1'b0;
            fifo_mem                   <= '0;
            fifo_wr_ptr                <= 1'b0;
            fifo_rd_ptr                <= 1'b0;
            fifo_occ                   <= 2'd0;
            out_valid                  <= 1'b0;
            page_rank_scatter          <= '0;
            dest_id                    <= '0;
            scatter_operation_complete <= 1'b0;
            edge_error                 <= 1'b0;
        end else if (nextIteration) begin
            state                      <= (count_eff == '0) ? S_DRAIN : S_ISSUE;
            edge_total                 <= count_eff;
            issue_idx                  <= '0;
            rd_pending                 <= 1'b0;
            fifo_wr_ptr                <= 1'b0;
            fifo_rd_ptr                <= 1'b0;
            fifo_occ                   <= 2'd0;
            out_valid                  <= 1'b0;
            scatter_operation_complete <= 1'b0;
            edge_error                 <= count_clamp;
        end else begin
            rd_pending <= edge_rd_en;

            if (edge_rd_en) begin
                issue_idx <= issue_idx + CNT_W'(1);
                if (issue_idx == edge_total - CNT_W'(1)) begin
                    state <= S_DRAIN;
                end
            end

            // Returned read data is always captured, even while disabled.
            if (rd_pending) begin
                fifo_mem[fifo_wr_ptr] <= edge_rd_data;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            fifo_occ <= fifo_occ + 2'(rd_pending) - 2'(pop);

            if (pagerank_enable) begin
                out_valid <= pop && head_in_range;
                if (pop && head_in_range) begin
                    page_rank_scatter <= contribution;
                    dest_id           <= head_dst;
                end
                if (pop && !head_in_range) begin
                    edge_error <= 1'b1;
                end
            end

            if (state == S_DRAIN && drain_done) begin
                state                      <= S_DONE;
                scatter_operation_complete <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
